// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: opcodes, FSM encoding and
// the layout of a result FIFO entry.
package alu_issue_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam int ENTRY_W = 7;

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [2:0] op,
                                                    input logic [3:0] res);
    return {op, res};
  endfunction

endpackage

// File: rtl/alu_issue_res_fifo.sv
// Result FIFO: power-of-two depth, pointers wrap naturally, and a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             valid_q;
  logic             do_rd_s;
  logic             do_wr_s;

  // Qualify the strobes and work out the next occupancy.
  always_comb begin
    do_rd_s = rd_en_i && valid_q;
    do_wr_s = wr_en_i && ((count_q != FULL_CNT) || do_rd_s);
    count_d = count_q;
    if (do_wr_s && !do_rd_s) begin
      count_d = count_q + CW'(1);
    end else if (do_rd_s && !do_wr_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer, occupancy and non-empty flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_rd_s) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Storage array; cleared on reset so stale results never reappear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr_s) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign valid_o   = valid_q;
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;

endmodule

// File: rtl/alu_issue.sv
// Operand/opcode entry sequencer for an external ALU; each finished
// operation is captured as {op, result} into a small result FIFO.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   cancel,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_op,
  input  logic [3:0]             alu_res,
  output logic [ENTRY_W-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  state_t     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] op_q;
  logic       in_ready_q;
  logic       full_s;
  logic       pop_s;
  logic       push_s;

  assign pop_s  = out_valid && out_ready;
  assign push_s = (state_q == ST_CAPTURE) && (!full_s || pop_s);

  // Entry sequencer; cancel outranks a simultaneous in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_GET_A;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      op_q       <= 3'd0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_GET_A: begin
          if (in_valid && !cancel) begin
            a_q     <= in_data;
            state_q <= ST_GET_B;
          end else begin
            state_q <= ST_GET_A;
          end
        end
        ST_GET_B: begin
          if (cancel) begin
            state_q <= ST_GET_A;
          end else if (in_valid) begin
            b_q     <= in_data;
            state_q <= ST_GET_OP;
          end else begin
            state_q <= ST_GET_B;
          end
        end
        ST_GET_OP: begin
          if (cancel) begin
            state_q <= ST_GET_A;
          end else if (in_valid) begin
            op_q       <= in_data[2:0];
            state_q    <= ST_ISSUE;
            in_ready_q <= 1'b0;
          end else begin
            state_q <= ST_GET_OP;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (push_s) begin
            state_q    <= ST_GET_A;
            in_ready_q <= 1'b1;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        default: begin
          state_q    <= ST_GET_A;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (push_s),
    .wr_data_i (pack_entry(op_q, alu_res)),
    .rd_en_i   (pop_s),
    .rd_data_o (out_data),
    .valid_o   (out_valid),
    .full_o    (full_s),
    .count_o   (count)
  );

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a reference ALU and a result scoreboard.
module tb_alu_issue;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [3:0]             in_data = 4'd0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   cancel = 1'b0;
  logic [3:0]             alu_a;
  logic [3:0]             alu_b;
  logic [2:0]             alu_op;
  logic [3:0]             alu_res;
  logic [6:0]             out_data;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad = 0;
  logic [6:0] exp_q[$];

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cancel    (cancel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference ALU driving the result input.
  always_comb begin
    case (alu_op)
      3'd0:    alu_res = alu_a + alu_b;
      3'd1:    alu_res = alu_a - alu_b;
      3'd2:    alu_res = ~alu_a;
      3'd3:    alu_res = alu_a & alu_b;
      3'd4:    alu_res = alu_a | alu_b;
      3'd5:    alu_res = alu_a ^ alu_b;
      3'd6:    alu_res = (alu_a < alu_b) ? 4'd1 : 4'd0;
      3'd7:    alu_res = (alu_a == alu_b) ? 4'd1 : 4'd0;
      default: alu_res = 4'd0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected nothing", out_data);
      end else begin
        chk("fifo_head", {25'd0, out_data}, {25'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic strobe(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [6:0] e);
    wait_ready();
    strobe(a);
    strobe(b);
    strobe(op);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((count != 0 || exp_q.size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_count", {29'd0, count}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #10;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Two-cycle latency from the opcode strobe to the FIFO write.
    out_ready = 1'b1;
    issue(4'd3, 4'd5, 4'd0, 7'h08);
    @(posedge clk);
    #1;
    chk("latency_cyc1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("latency_cyc2_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_cyc2_data", {25'd0, out_data}, 32'h08);

    issue(4'd3, 4'd5, 4'd1, 7'h1E);
    issue(4'd5, 4'd0, 4'd2, 7'h2A);
    issue(4'hC, 4'hA, 4'd3, 7'h38);
    issue(4'hC, 4'd3, 4'd4, 7'h4F);
    issue(4'd6, 4'd3, 4'd5, 7'h55);
    issue(4'd2, 4'd9, 4'd6, 7'h61);
    issue(4'd9, 4'd9, 4'h8, 7'h02);
    drain();
    @(posedge clk);
    #1;
    chk("pop_empty_count", {29'd0, count}, 32'd0);

    // Fill to full, fifth result waits in capture until a pop frees a slot.
    out_ready = 1'b0;
    issue(4'd1, 4'd1, 4'd0, 7'h02);
    issue(4'd2, 4'd2, 4'd0, 7'h04);
    issue(4'd3, 4'd3, 4'd0, 7'h06);
    issue(4'd4, 4'd4, 4'd0, 7'h08);
    issue(4'd5, 4'd5, 4'd0, 7'h0A);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("push_pop_count", {29'd0, count}, 32'd4);
    chk("push_pop_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Cancel after operand A keeps A and restarts entry.
    wait_ready();
    strobe(4'd9);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("cancel_keeps_a", {28'd0, alu_a}, 32'd9);
    issue(4'd2, 4'd2, 4'd7, 7'h71);
    drain();

    // Cancel wins over a simultaneous in_valid in GET_B.
    wait_ready();
    strobe(4'd4);
    in_data  = 4'hF;
    in_valid = 1'b1;
    cancel   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cancel   = 1'b0;
    chk("cancel_wins_b", {28'd0, alu_b}, 32'd2);
    strobe(4'd7);
    chk("after_cancel_a", {28'd0, alu_a}, 32'd7);
    chk("after_cancel_b", {28'd0, alu_b}, 32'd2);
    strobe(4'd2);
    strobe(4'd0);
    exp_q.push_back(7'h09);
    drain();

    // Reset while a result is pending in capture with two entries queued.
    out_ready = 1'b0;
    issue(4'd1, 4'd2, 4'd0, 7'h03);
    issue(4'd3, 4'd4, 4'd0, 7'h07);
    issue(4'd5, 4'd5, 4'd0, 7'h0A);
    @(posedge clk);
    #1;
    chk("pre_rst_count", {29'd0, count}, 32'd2);
    rst = 1'b0;
    #2;
    exp_q.delete();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_alu_a", {28'd0, alu_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    issue(4'hF, 4'd1, 4'd1, 7'h1E);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DEPTH, default 4, is the result FIFO depth (power of two, ≥2).
REQ-002 Port clk, input, 1, the single rising-edge clock.
REQ-003 Port rst, input, 1, asynchronous active-low reset.
REQ-004 Port in_data, input, 4, operand/opcode value from switches.
REQ-005 Port in_valid, input, 1, one-cycle entry strobe, already synchronised and edge-detected.
REQ-006 Port in_ready, output, 1, high while an entry is accepted (states GET_A, GET_B, GET_OP).
REQ-007 Port cancel, input, 1, one-cycle strobe that abandons the current entry sequence.
REQ-008 Port alu_a, output, 4, registered ALU operand A.
REQ-009 Port alu_b, output, 4, registered ALU operand B.
REQ-010 Port alu_op, output, 3, registered ALU opcode.
REQ-011 Port alu_res, input, 4, combinational ALU result (pre-7-segment value).
REQ-012 Port out_data, output, 7, FIFO head {op[2:0], res[3:0]}.
REQ-013 Port out_valid, output, 1, FIFO non-empty.
REQ-014 Port out_ready, input, 1, consumer accepts the head.
REQ-015 Port count, output, log2(DEPTH)+1, FIFO occupancy.

Function
REQ-016 The FSM SHALL have states GET_A, GET_B, GET_OP, ISSUE and CAPTURE.
REQ-017 In GET_A, in_valid SHALL load alu_a <= in_data and move to GET_B.
REQ-018 In GET_B, in_valid SHALL load alu_b <= in_data and move to GET_OP.
REQ-019 In GET_OP, in_valid SHALL load alu_op <= in_data[2:0] (bit 3 ignored) and move to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle (ALU settle) and then go to CAPTURE.
REQ-021 In CAPTURE, when the FIFO accepts a push, {alu_op, alu_res} SHALL be written and the FSM SHALL return to GET_A; otherwise it SHALL hold in CAPTURE.
REQ-022 A push SHALL be accepted when count < DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
REQ-023 A pop SHALL occur when out_valid && out_ready; a pop while empty SHALL have no effect.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 in_valid SHALL be ignored while in ISSUE or CAPTURE.
REQ-027 cancel in GET_B or GET_OP SHALL return the FSM to GET_A without altering alu_a, alu_b or alu_op; cancel in GET_A, ISSUE or CAPTURE SHALL be ignored.
REQ-028 cancel and in_valid asserted in the same cycle SHALL be resolved in favour of cancel.
REQ-029 alu_a, alu_b and alu_op SHALL hold their values until the next load.
REQ-030 Result latency SHALL be 2 cycles from the GET_OP strobe to FIFO write when the FIFO is not full.

Reset
REQ-031 On rst low, the FSM SHALL enter GET_A immediately (asynchronously).
REQ-032 On rst low, alu_a, alu_b, alu_op, count and the pointers SHALL be 0, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-033 Reset in any state, including mid-CAPTURE, SHALL discard the pending result and all FIFO contents.

Structure
REQ-034 A shared package SHALL hold the opcode constants OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_CMP=6, OP_EQ=7, the FSM state encoding and the FIFO entry width (7).
REQ-035 The FIFO SHALL be a separate sub-module named res_fifo, parameterised by DEPTH and width.
REQ-036 The ALU itself SHALL be outside this block; it is connected only through alu_a, alu_b, alu_op and alu_res.

Verification
REQ-037 Enter 3, 5, op 0 with the ALU as the model -> out_data = {3'd0, 4'h8} two cycles after the op strobe.
REQ-038 Enter 3, 5, op 1 -> out_data = {3'd1, 4'hE}.
REQ-039 Hold out_ready=0 and issue 5 commands -> count = 4, the FSM sits in CAPTURE with in_ready=0; one pop -> the 5th result is written in the same cycle and count stays 4.
REQ-040 Enter A=9, then cancel, then enter 2, 2, op 7 -> out_data = {3'd7, 4'h1}.
REQ-041 Assert rst low during CAPTURE with 2 entries queued -> out_valid=0, count=0, in_ready=1 while rst is low.
REQ-042 Assert in_valid and cancel together in GET_B -> the FSM goes to GET_A and alu_b is unchanged.
